// File: rtl/hilo_muldiv_if.sv
// EXE-stage to HI/LO unit bus: instruction/operands in, stall and HI/LO state out.
interface hilo_muldiv_if #(
  parameter int unsigned WIDTH = 32
);
  logic             op_valid;
  logic [2:0]       op;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             ex_flush;
  logic             mem_allowin;
  logic             exe_readygo;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output op_valid, op, src_a, src_b, ex_flush, mem_allowin,
    input  exe_readygo, busy, hi, lo
  );

  modport slave (
    input  op_valid, op, src_a, src_b, ex_flush, mem_allowin,
    output exe_readygo, busy, hi, lo
  );
endinterface

// File: rtl/hilo_muldiv_seq.sv
// HI/LO unit sequencer: single-cycle MULT/MULTU, WIDTH-cycle restoring DIV/DIVU,
// MTHI/MTLO; commits only when the instruction leaves EXE uncancelled.
module hilo_muldiv_seq #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] HILO_RST = '0
) (
  input  logic          clk,
  input  logic          rst,
  hilo_muldiv_if.slave  bus
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIV_RUN = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
  logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d, div0_q, div0_d;
  logic               readygo_c;

  logic               is_div, div_signed, mul_signed, fire_idle;
  logic [2*WIDTH-1:0] ext_a, ext_b, prod;
  logic [WIDTH:0]     rem_sh, trial;

  assign is_div     = bus.op_valid & ((bus.op == OP_DIV) | (bus.op == OP_DIVU));
  assign div_signed = (bus.op == OP_DIV);
  assign mul_signed = (bus.op == OP_MULT);
  assign fire_idle  = bus.op_valid & bus.mem_allowin & ~bus.ex_flush;

  // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are exact either way.
  assign ext_a = {{WIDTH{mul_signed & bus.src_a[WIDTH-1]}}, bus.src_a};
  assign ext_b = {{WIDTH{mul_signed & bus.src_b[WIDTH-1]}}, bus.src_b};
  assign prod  = ext_a * ext_b;

  // Restoring step: remainder stays below the divisor, so trial[WIDTH] is the borrow.
  assign rem_sh = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, div_b_q};

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    div_a_d   = div_a_q;
    div_b_d   = div_b_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    div0_d    = div0_q;
    readygo_c = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (is_div & ~bus.ex_flush) begin
          readygo_c = 1'b0;
          state_d   = S_DIV_RUN;
          cnt_d     = '0;
          rem_d     = '0;
          div_a_d   = bus.src_a;
          quo_d     = (div_signed & bus.src_a[WIDTH-1]) ? -bus.src_a : bus.src_a;
          div_b_d   = (div_signed & bus.src_b[WIDTH-1]) ? -bus.src_b : bus.src_b;
          q_neg_d   = div_signed & (bus.src_a[WIDTH-1] ^ bus.src_b[WIDTH-1]);
          r_neg_d   = div_signed & bus.src_a[WIDTH-1];
          div0_d    = (bus.src_b == '0);
        end else if (fire_idle) begin
          unique case (bus.op)
            OP_MULT, OP_MULTU: {hi_d, lo_d} = prod;
            OP_MTHI:           hi_d = bus.src_a;
            OP_MTLO:           lo_d = bus.src_a;
            default:           ;
          endcase
        end
      end

      S_DIV_RUN: begin
        readygo_c = 1'b0;
        if (bus.ex_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          rem_d = trial[WIDTH] ? rem_sh : trial;
          quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
      end

      S_DONE: begin
        if (bus.ex_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (bus.mem_allowin) begin
          state_d = S_IDLE;
          if (div0_q) begin
            lo_d = '1;
            hi_d = div_a_q;
          end else begin
            lo_d = q_neg_q ? -quo_q : quo_q;
            hi_d = r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= HILO_RST;
      lo_q    <= HILO_RST;
      quo_q   <= '0;
      rem_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      div0_q  <= div0_d;
    end
  end

  assign bus.exe_readygo = readygo_c;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;

endmodule
